// File: rtl/note_sequencer.sv
// Note sequencer: walks a {length, pitch} note memory and drives a pitch code
// to the tone generator, with tick prescaling, articulation gap, pause/stop and looping.
module note_sequencer #(
    parameter int ADDR_W    = 10,
    parameter int PITCH_W   = 8,
    parameter int LEN_W     = 8,
    parameter int TICK_DIV  = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic                       oclk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pause,
    input  logic                       loop_en,
    input  logic [PITCH_W+LEN_W-1:0]   data,
    output logic [ADDR_W-1:0]          cnt,
    output logic [PITCH_W-1:0]         outv,
    output logic                       playing,
    output logic                       note_strobe,
    output logic                       done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [LEN_W-1:0]  GAP_LEN  = LEN_W'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   ticks_left;
    logic [PRE_W-1:0]   prescaler;
    logic [PITCH_W-1:0] pitch_r;

    logic [LEN_W-1:0]   len_f;
    logic [PITCH_W-1:0] pitch_f;
    logic               tick;

    assign len_f   = data[PITCH_W+LEN_W-1:PITCH_W];
    assign pitch_f = data[PITCH_W-1:0];
    assign tick    = (prescaler == PRE_MAX);

    // Sequencing FSM with note timing and one-cycle event pulses
    always_ff @(posedge oclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ticks_left  <= '0;
            prescaler   <= '0;
            pitch_r     <= '0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cnt   <= '0;
                            state <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        if (len_f == '0) begin
                            if (loop_en) begin
                                cnt   <= '0;
                                state <= FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            pitch_r     <= pitch_f;
                            ticks_left  <= len_f;
                            prescaler   <= '0;
                            note_strobe <= 1'b1;
                            state       <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (!pause) begin
                            if (tick) begin
                                prescaler <= '0;
                                if (ticks_left > LEN_W'(1)) begin
                                    ticks_left <= ticks_left - LEN_W'(1);
                                // last address acts as an implicit end marker: never wrap silently
                                end else if (cnt == ADDR_MAX) begin
                                    if (loop_en) begin
                                        cnt   <= '0;
                                        state <= FETCH;
                                    end else begin
                                        done  <= 1'b1;
                                        state <= IDLE;
                                    end
                                end else begin
                                    cnt   <= cnt + ADDR_W'(1);
                                    state <= FETCH;
                                end
                            end else begin
                                prescaler <= prescaler + PRE_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Output decode from state registers; pause mutes immediately
    always_comb begin
        outv    = '0;
        playing = (state != IDLE);
        if ((state == PLAY) && (ticks_left > GAP_LEN) && !pause) begin
            outv = pitch_r;
        end else begin
            outv = '0;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: cycle table for basic playback plus
// hand-written sequences for loop, stop, pause, async reset and address-end cases.
module tb_note_sequencer;

    logic        oclk = 1'b0;
    logic        rst, start, stop, pause, loop_en;
    logic [15:0] data;
    logic [9:0]  cnt;
    logic [7:0]  outv;
    logic        playing, note_strobe, done;

    logic        s_start, s_stop, s_pause, s_loop;
    logic [15:0] s_data;
    logic [1:0]  s_cnt;
    logic [7:0]  s_outv;
    logic        s_playing, s_strobe, s_done;

    logic [15:0] mem [0:1023];
    logic [15:0] s_mem [0:3];

    int passed = 0;
    int total  = 0;

    always #5 oclk = ~oclk;

    always @(posedge oclk) data   <= mem[cnt];
    always @(posedge oclk) s_data <= s_mem[s_cnt];

    note_sequencer #(.ADDR_W(10), .PITCH_W(8), .LEN_W(8), .TICK_DIV(4), .GAP_TICKS(1)) dut (
        .oclk(oclk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
        .data(data), .cnt(cnt), .outv(outv), .playing(playing),
        .note_strobe(note_strobe), .done(done)
    );

    note_sequencer #(.ADDR_W(2), .PITCH_W(8), .LEN_W(8), .TICK_DIV(1), .GAP_TICKS(0)) dut_small (
        .oclk(oclk), .rst(rst), .start(s_start), .stop(s_stop), .pause(s_pause), .loop_en(s_loop),
        .data(s_data), .cnt(s_cnt), .outv(s_outv), .playing(s_playing),
        .note_strobe(s_strobe), .done(s_done)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic       loop_en;
        logic [7:0] outv;
        logic       playing;
        logic       strobe;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge oclk);
        #1;
    endtask

    task automatic add(input int n, input logic st, input logic sp, input logic ps, input logic lp,
                       input logic [7:0] ov, input logic pl, input logic sb, input logic dn);
        vec_t v;
        v.start = st; v.stop = sp; v.pause = ps; v.loop_en = lp;
        v.outv = ov; v.playing = pl; v.strobe = sb; v.done = dn;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic wait_w0(output int n);
        n = 0;
        while (!(note_strobe && outv == 8'h40) && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, n2, samples, plays, strobes;
        logic seen_done, seen3, wrapped;

        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0340;
        mem[1] = 16'h0200;
        mem[2] = 16'h0000;
        for (int i = 0; i < 4; i++) s_mem[i] = {8'd1, 8'(i + 1)};

        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        s_start = 1'b0; s_stop = 1'b0; s_pause = 1'b0; s_loop = 1'b0;
        repeat (2) @(posedge oclk);
        #1 rst = 1'b0;

        check("rst_outv", 32'(outv), 32'h0);
        check("rst_playing", 32'(playing), 32'h0);
        check("rst_cnt", 32'(cnt), 32'h0);
        check("rst_strobe", 32'(note_strobe), 32'h0);
        check("rst_done", 32'(done), 32'h0);

        // start+stop together stays idle, then a full non-looping song
        add(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0);
        add(7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
        add(4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        add(7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; stop = vecs[i].stop;
            pause = vecs[i].pause; loop_en = vecs[i].loop_en;
            step();
            check($sformatf("vec%0d", i), 32'({outv, playing, note_strobe, done}),
                  32'({vecs[i].outv, vecs[i].playing, vecs[i].strobe, vecs[i].done}));
        end
        check("cnt_after_done", 32'(cnt), 32'd2);

        // looping: w0 strobe period
        loop_en = 1'b1; start = 1'b1; step(); start = 1'b0;
        wait_w0(n);
        check("first_strobe_lat", 32'(n), 32'd2);
        step();
        wait_w0(n2);
        check("loop_period", 32'(n2 + 1), 32'd26);
        check("loop_cnt", 32'(cnt), 32'd0);

        // stop mid-w1, then restart from address 0
        repeat (14) step();
        check("w1_strobe", 32'({note_strobe, cnt}), 32'({1'b1, 10'd1}));
        repeat (3) step();
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_idle", 32'({playing, outv, done}), 32'h0);
        check("stop_cnt_hold", 32'(cnt), 32'd1);
        repeat (3) step();
        check("stop_no_done", 32'({playing, done}), 32'h0);
        loop_en = 1'b0; start = 1'b1; step(); start = 1'b0;
        wait_w0(n);
        check("restart_lat", 32'(n), 32'd2);
        check("restart_cnt", 32'(cnt), 32'd0);

        // pause five cycles inside w0
        samples = 1; plays = 1;
        repeat (3) begin
            step(); samples++;
            if (outv == 8'h40) plays++;
        end
        pause = 1'b1;
        repeat (5) begin
            step(); samples++;
            check("pause_mute", 32'(outv), 32'h0);
        end
        pause = 1'b0;
        for (int g = 0; g < 100; g++) begin
            step();
            if (cnt != 10'd0) break;
            samples++;
            if (outv == 8'h40) plays++;
        end
        check("pause_play_len", 32'(samples), 32'd17);
        check("pause_sound_len", 32'(plays), 32'd8);
        seen_done = 1'b0;
        for (int g = 0; g < 50 && !seen_done; g++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        check("done_after_pause", 32'(seen_done), 32'd1);

        // async reset between edges mid-note
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        check("pre_rst_outv", 32'(outv), 32'h40);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", 32'({outv, playing}), 32'h0);
        check("async_rst_cnt", 32'(cnt), 32'd0);
        #2 rst = 1'b0;
        step();
        check("post_rst_idle", 32'({playing, note_strobe, outv}), 32'h0);

        // small address space, no end marker, no loop
        s_loop = 1'b0; s_start = 1'b1; step(); s_start = 1'b0;
        strobes = 0; seen_done = 1'b0;
        for (int g = 0; g < 40 && !seen_done; g++) begin
            step();
            if (s_strobe) strobes++;
            if (s_done) begin
                seen_done = 1'b1;
                check("small_done_cnt", 32'(s_cnt), 32'd3);
            end
        end
        check("small_done_seen", 32'(seen_done), 32'd1);
        check("small_strobes", 32'(strobes), 32'd4);
        repeat (3) step();
        check("small_no_wrap", 32'({s_playing, s_cnt}), 32'({1'b0, 2'd3}));

        // small address space with loop: wraps to 0
        s_loop = 1'b1; s_start = 1'b1; step(); s_start = 1'b0;
        seen3 = 1'b0; wrapped = 1'b0;
        for (int g = 0; g < 40 && !wrapped; g++) begin
            step();
            if (s_cnt == 2'd3) seen3 = 1'b1;
            if (seen3 && s_cnt == 2'd0) wrapped = 1'b1;
            if (s_done) check("small_loop_no_done", 32'(s_done), 32'd0);
        end
        check("small_wrapped", 32'(wrapped), 32'd1);
        check("small_loop_playing", 32'(s_playing), 32'd1);
        s_stop = 1'b1; step(); s_stop = 1'b0;
        check("small_stop", 32'(s_playing), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
